// File: rtl/ex_hazard_ctrl_if.sv
// EX-stage hazard control bundle: pipeline register fields in,
// forwarding selects and stall/flush controls out.
interface ex_hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rs1_addr;
  logic [4:0] ex_rs2_addr;
  logic [4:0] ex_rd_addr;
  logic       ex_wb_en;
  logic       ex_is_load;
  logic       ex_is_mul;
  logic [4:0] mem_rd_addr;
  logic       mem_wb_en;
  logic [4:0] wb_rd_addr;
  logic       wb_wb_en;
  logic [1:0] mux1_sel;
  logic [1:0] mux2_sel;
  logic       stall_pc;
  logic       stall_id;
  logic       flush_ex;
  logic       hold_ex;
  logic       kill_mem;
  logic       mul_busy;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_wb_en,
    output ex_is_load, ex_is_mul,
    output mem_rd_addr, mem_wb_en, wb_rd_addr, wb_wb_en,
    input  mux1_sel, mux2_sel, stall_pc, stall_id,
    input  flush_ex, hold_ex, kill_mem, mul_busy
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_wb_en,
    input  ex_is_load, ex_is_mul,
    input  mem_rd_addr, mem_wb_en, wb_rd_addr, wb_wb_en,
    output mux1_sel, mux2_sel, stall_pc, stall_id,
    output flush_ex, hold_ex, kill_mem, mul_busy
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage forwarding, load-use and multi-cycle multiply control.
// Define EX_MUL_MULTICYCLE_EN to enable the multiply sequencing FSM.
module ex_hazard_ctrl #(
  parameter int MUL_LAT = 3
) (
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave hz
);

  logic m1, w1, m2, w2;
  logic lu_raw, lu_hit;
  logic mul_stall, mul_cyc;

  assign m1 = hz.mem_wb_en && (hz.mem_rd_addr != 5'd0)
           && (hz.mem_rd_addr == hz.ex_rs1_addr);
  assign w1 = hz.wb_wb_en && (hz.wb_rd_addr != 5'd0)
           && (hz.wb_rd_addr == hz.ex_rs1_addr);
  assign m2 = hz.mem_wb_en && (hz.mem_rd_addr != 5'd0)
           && (hz.mem_rd_addr == hz.ex_rs2_addr);
  assign w2 = hz.wb_wb_en && (hz.wb_rd_addr != 5'd0)
           && (hz.wb_rd_addr == hz.ex_rs2_addr);

  always_comb begin
    hz.mux1_sel = 2'b00;
    unique case (1'b1)
      m1:       hz.mux1_sel = 2'b01;
      w1 && !m1: hz.mux1_sel = 2'b10;
      default:  ;
    endcase
  end

  always_comb begin
    hz.mux2_sel = 2'b00;
    unique case (1'b1)
      m2:       hz.mux2_sel = 2'b01;
      w2 && !m2: hz.mux2_sel = 2'b10;
      default:  ;
    endcase
  end

  assign lu_raw = hz.ex_is_load && hz.ex_wb_en
               && (hz.ex_rd_addr != 5'd0)
               && ((hz.id_use_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr))
                || (hz.id_use_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));

`ifdef EX_MUL_MULTICYCLE_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // rst gates the start so stalls drop while reset is held low
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_stall = 1'b0;
    mul_cyc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst && hz.ex_is_mul && (MUL_LAT > 1)) begin
          mul_stall = 1'b1;
          mul_cyc   = 1'b1;
          state_nxt = MUL_BUSY;
          cnt_nxt   = 3'(MUL_LAT - 2);
        end
      end
      MUL_BUSY: begin
        mul_cyc = 1'b1;
        if (cnt != 3'd0) begin
          mul_stall = 1'b1;
          cnt_nxt   = cnt - 3'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hz.mul_busy = (state == MUL_BUSY);
`else
  localparam int unused_lat = MUL_LAT;
  logic unused_in;

  assign unused_in   = ^{clk, rst, hz.ex_is_mul};
  assign mul_stall   = 1'b0;
  assign mul_cyc     = 1'b0;
  assign hz.mul_busy = 1'b0;
`endif

  assign lu_hit      = lu_raw && !mul_cyc;
  assign hz.stall_pc = mul_stall || lu_hit;
  assign hz.stall_id = mul_stall || lu_hit;
  assign hz.flush_ex = lu_hit;
  assign hz.hold_ex  = mul_stall;
  assign hz.kill_mem = mul_stall;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed plus random vectors
// against a cycle-age reference model of the hazard rules.
module tb_ex_hazard_ctrl;

  localparam int LAT = 3;
`ifdef EX_MUL_MULTICYCLE_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_u1;
    logic       id_u2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_wb;
    logic       ex_ld;
    logic       ex_mul;
    logic [4:0] mem_rd;
    logic       mem_wb;
    logic [4:0] wb_rd;
    logic       wb_wb;
  } stim_t;

  typedef struct {
    logic [9:0] o;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  ex_hazard_ctrl_if hz();

  ex_hazard_ctrl #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   age = 0;

  function automatic logic [1:0] fwd(stim_t s, logic [4:0] rs);
    if (s.mem_wb && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    if (s.wb_wb && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // age: 0 idle, k>=2 is the k-th cycle of a multiply's EX occupancy
  function automatic logic [9:0] model(stim_t s, bit rstn, int a);
    bit start, busy, inmul, mst, lu, stall;
    if (!rstn) a = 0;
    start = MULTI && rstn && a == 0 && s.ex_mul && LAT > 1;
    busy  = a >= 2;
    inmul = start || busy;
    mst   = start || (busy && a < LAT);
    lu = s.ex_ld && s.ex_wb && s.ex_rd != 0
      && ((s.id_u1 && s.id_rs1 == s.ex_rd)
       || (s.id_u2 && s.id_rs2 == s.ex_rd)) && !inmul;
    stall = mst || lu;
    return {fwd(s, s.ex_rs1), fwd(s, s.ex_rs2),
            stall, stall, lu, mst, mst, busy};
  endfunction

  task automatic drive(input stim_t s, input bit rstn, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rstn;
    hz.id_rs1_addr = s.id_rs1;
    hz.id_rs2_addr = s.id_rs2;
    hz.id_use_rs1  = s.id_u1;
    hz.id_use_rs2  = s.id_u2;
    hz.ex_rs1_addr = s.ex_rs1;
    hz.ex_rs2_addr = s.ex_rs2;
    hz.ex_rd_addr  = s.ex_rd;
    hz.ex_wb_en    = s.ex_wb;
    hz.ex_is_load  = s.ex_ld;
    hz.ex_is_mul   = s.ex_mul;
    hz.mem_rd_addr = s.mem_rd;
    hz.mem_wb_en   = s.mem_wb;
    hz.wb_rd_addr  = s.wb_rd;
    hz.wb_wb_en    = s.wb_wb;
    e.o   = model(s, rstn, age);
    e.tag = tag;
    sb.push_back(e);
    if (!rstn) age = 0;
    else if (age == 0)
      age = (MULTI && s.ex_mul && LAT > 1) ? 2 : 0;
    else age = (age == LAT) ? 0 : age + 1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e = sb.pop_front();
      got = {hz.mux1_sel, hz.mux2_sel, hz.stall_pc, hz.stall_id,
             hz.flush_ex, hz.hold_ex, hz.kill_mem, hz.mul_busy};
      vectors++;
      if (got !== e.o) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", e.tag, got, e.o);
      end
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s.id_rs1 = 5'($urandom_range(0, 3));
    s.id_rs2 = 5'($urandom_range(0, 3));
    s.id_u1  = 1'($urandom_range(0, 1));
    s.id_u2  = 1'($urandom_range(0, 1));
    s.ex_rs1 = 5'($urandom_range(0, 3));
    s.ex_rs2 = 5'($urandom_range(0, 3));
    s.ex_rd  = 5'($urandom_range(0, 3));
    s.ex_wb  = 1'($urandom_range(0, 1));
    s.ex_ld  = 1'($urandom_range(0, 1));
    s.ex_mul = ($urandom_range(0, 7) == 0);
    s.mem_rd = 5'($urandom_range(0, 3));
    s.mem_wb = 1'($urandom_range(0, 1));
    s.wb_rd  = 5'($urandom_range(0, 3));
    s.wb_wb  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s, lu;
    int n;
    rst = 1'b0;
    s = '0;
    drive(s, 1'b0, "reset_a");
    drive(s, 1'b0, "reset_b");

    s.ex_rs1 = 5; s.mem_rd = 5; s.mem_wb = 1; s.wb_rd = 5; s.wb_wb = 1;
    drive(s, 1'b1, "fwd_mem_prio");
    s.mem_wb = 0;
    drive(s, 1'b1, "fwd_wb");
    s.mem_wb = 1; s.mem_rd = 0; s.wb_rd = 0;
    drive(s, 1'b1, "fwd_x0");
    s = '0; s.ex_rs2 = 9; s.wb_rd = 9; s.wb_wb = 1;
    drive(s, 1'b1, "fwd_rs2_wb");

    lu = '0;
    lu.ex_ld = 1; lu.ex_wb = 1; lu.ex_rd = 7;
    lu.id_u2 = 1; lu.id_rs2 = 7;
    drive(lu, 1'b1, "loaduse");
    s = '0; s.ex_rs2 = 7; s.mem_rd = 7; s.mem_wb = 1;
    drive(s, 1'b1, "loaduse_fwd");
    s = lu; s.ex_rd = 0; s.id_rs2 = 0;
    drive(s, 1'b1, "loaduse_x0");
    s = lu; s.id_u2 = 0;
    drive(s, 1'b1, "loaduse_nouse");

    s = '0; s.ex_mul = 1;
    drive(s, 1'b1, "mul_c0");
    s.ex_mul = 0;
    for (int i = 0; i < 3; i++) drive(s, 1'b1, "mul_tail");

    s = lu; s.ex_mul = 1;
    for (int i = 0; i < 6; i++) drive(s, 1'b1, "mul_b2b");
    s = '0;
    drive(s, 1'b1, "mul_b2b_end");

    s.ex_mul = 1;
    drive(s, 1'b1, "rst_mul_start");
    drive(s, 1'b1, "rst_mul_busy");
    drive(s, 1'b0, "rst_mid_mul");
    s.ex_mul = 0;
    drive(s, 1'b1, "rst_release");
    drive(s, 1'b1, "rst_idle");

    for (int i = 0; i < 400; i++) drive(rnd(), 1'b1, "random");

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
